canvas_rect_writer: RTL and testbench
=====================================

# canvas_rect_writer

Rectangle-fill engine sitting directly upstream of the canvas frame-buffer controller. Accepts one rectangle command at a time over a valid/ready handshake, clips it to the canvas, and emits one pixel write per clock (writeX, writeY, write_enable, write_color) in raster order. These outputs connect straight to the canvas controller's write port. Used for brush strokes, fills and full-canvas clears.

## Interface
- color_palette_bit, 2, palette index width; must equal the canvas controller's value
- width, 100, canvas width in pixels (≤ 1024)
- height, 100, canvas height in pixels (≤ 1024)

- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_y0  in  10 each  first corner, unsigned
- cmd_x1, cmd_y1  in  10 each  opposite corner, unsigned; either corner ordering allowed
- cmd_color  in  color_palette_bit  palette index to write
- writeX, writeY  out  10 each  pixel address to canvas
- write_enable  out  1  write strobe, one pixel per cycle
- write_color  out  color_palette_bit  palette index for the current write
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, FILL, DONE.
- IDLE: cmd_ready = 1. Handshake fires on the edge where cmd_valid && cmd_ready. The engine latches the normalised, clipped rectangle and the color.
  - xlo = min(x0,x1), xhi = min(max(x0,x1), width-1); y likewise with height-1.
  - If xlo ≥ width or ylo ≥ height, the rectangle is empty: go to DONE with no writes.
  - Otherwise go to FILL with cursor at (xlo, ylo).
- FILL: write_enable = 1 every cycle at the current cursor.
  - Cursor advances x first. At xhi, x wraps to xlo and y increments.
  - After the write at (xhi, yhi), go to DONE.
  - Pixel count is exactly (xhi-xlo+1)·(yhi-ylo+1).
- DONE: held for exactly one cycle. done = 1, write_enable = 0, then return to IDLE.
- cmd_ready = (state == IDLE). No command queueing. Command inputs are ignored outside IDLE and may change freely there.
- busy = (state != IDLE).
- write_color is held at the latched color for the whole command. Inputs never affect an in-flight command.
- All arithmetic is 10-bit unsigned. Comparisons use the width-1/height-1 constants, so there is no overflow.

## Timing
- Reset values (immediate, asynchronous): state IDLE, cmd_ready 1, busy 0, done 0, write_enable 0, writeX 0, writeY 0, write_color 0.
- All outputs except cmd_ready are registered. cmd_ready is decoded from the state register.
- Handshake at edge N → first write_enable high in cycle N+1. The last pixel is in cycle N+P. done is high in cycle N+P+1. cmd_ready returns in cycle N+P+2.
- Empty command: done is high in cycle N+1, with no write_enable at all.
- 1×1 rectangle: exactly one write in cycle N+1, done in N+2.
- Back-to-back commands: the next handshake can occur at the earliest on the edge ending cycle N+P+2. There is never a gap inside a command.
- Reset mid-FILL: writes stop at once and no done pulse occurs. Pixels already written stay in the canvas.

## Structure
- Shared package canvas_pkg holds:
  - typedef coord_t (logic [9:0])
  - enum rect_state_t {IDLE, FILL, DONE}
  - localparam COORD_W = 10
- One combinational sub-module, canvas_rect_clip: corner normalisation plus clipping, with an empty flag output. The FSM and cursor counters stay in canvas_rect_writer.

## Test plan
- Reset then idle: outputs match the reset values. cmd_ready = 1 and write_enable never rises.
- Command (2,3)-(4,4), color 1: writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) in consecutive cycles, all color 1. done one cycle later. Total 6 writes.
- Swapped corners (4,4)-(2,3): identical write sequence to the previous case.
- Clipping at width = height = 100, command (98,99)-(200,300): writes (98,99),(99,99) only, then done. Command (150,10)-(160,20): no writes, done in cycle N+1.
- Full clear (0,0)-(99,99), color 0: exactly 10000 writes, last at (99,99). cmd_valid held high throughout never yields a second handshake before cmd_ready returns.
- rst_n pulled low at write 3 of a 6-pixel fill: write_enable drops immediately and no done pulse occurs. A new command after release behaves normally.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared types and helpers for the canvas drawing engines.
// Coordinates are 10-bit unsigned throughout.
package canvas_pkg;

   localparam int unsigned COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } rect_state_t;

   function automatic coord_t coord_min(input coord_t a, input coord_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic coord_t coord_max(input coord_t a, input coord_t b);
      return (a < b) ? b : a;
   endfunction

endpackage

// File: rtl/canvas_rect_clip.sv
// Normalises a rectangle's corners and clips it to the canvas.
// Purely combinational; empty flags a rectangle lying wholly off-canvas.
module canvas_rect_clip
   import canvas_pkg::*;
#(
   parameter int unsigned width  = 100,
   parameter int unsigned height = 100
) (
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] xlo,
   output logic [COORD_W-1:0] xhi,
   output logic [COORD_W-1:0] ylo,
   output logic [COORD_W-1:0] yhi,
   output logic               empty
);

   localparam coord_t XMax = coord_t'(width - 1);
   localparam coord_t YMax = coord_t'(height - 1);

   always_comb begin
      xlo   = coord_min(x0, x1);
      ylo   = coord_min(y0, y1);
      xhi   = coord_min(coord_max(x0, x1), XMax);
      yhi   = coord_min(coord_max(y0, y1), YMax);
      // Comparing against the max index avoids forming width/height in 10 bits.
      empty = (xlo > XMax) || (ylo > YMax);
   end

endmodule

// File: rtl/canvas_rect_writer.sv
// Rectangle-fill engine: accepts one command, clips it, then streams one
// pixel write per clock in raster order to the canvas controller.
module canvas_rect_writer
   import canvas_pkg::*;
#(
   parameter int unsigned color_palette_bit = 2,
   parameter int unsigned width             = 100,
   parameter int unsigned height            = 100
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [COORD_W-1:0]           cmd_x0,
   input  logic [COORD_W-1:0]           cmd_y0,
   input  logic [COORD_W-1:0]           cmd_x1,
   input  logic [COORD_W-1:0]           cmd_y1,
   input  logic [color_palette_bit-1:0] cmd_color,
   output logic [COORD_W-1:0]           writeX,
   output logic [COORD_W-1:0]           writeY,
   output logic                         write_enable,
   output logic [color_palette_bit-1:0] write_color,
   output logic                         busy,
   output logic                         done
);

   rect_state_t state_q;
   coord_t      xlo_q;
   coord_t      xhi_q;
   coord_t      yhi_q;

   coord_t clip_xlo;
   coord_t clip_xhi;
   coord_t clip_ylo;
   coord_t clip_yhi;
   logic   clip_empty;

   canvas_rect_clip #(
      .width  (width),
      .height (height)
   ) u_clip (
      .x0    (cmd_x0),
      .y0    (cmd_y0),
      .x1    (cmd_x1),
      .y1    (cmd_y1),
      .xlo   (clip_xlo),
      .xhi   (clip_xhi),
      .ylo   (clip_ylo),
      .yhi   (clip_yhi),
      .empty (clip_empty)
   );

   assign cmd_ready = (state_q == IDLE);

   // writeX/writeY double as the raster cursor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         xlo_q        <= '0;
         xhi_q        <= '0;
         yhi_q        <= '0;
         writeX       <= '0;
         writeY       <= '0;
         write_enable <= 1'b0;
         write_color  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  xlo_q       <= clip_xlo;
                  xhi_q       <= clip_xhi;
                  yhi_q       <= clip_yhi;
                  write_color <= cmd_color;
                  busy        <= 1'b1;
                  if (clip_empty) begin
                     state_q <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_q      <= FILL;
                     writeX       <= clip_xlo;
                     writeY       <= clip_ylo;
                     write_enable <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (writeX == xhi_q) begin
                  if (writeY == yhi_q) begin
                     state_q      <= DONE;
                     write_enable <= 1'b0;
                     done         <= 1'b1;
                  end else begin
                     writeX <= xlo_q;
                     writeY <= writeY + 10'd1;
                  end
               end else begin
                  writeX <= writeX + 10'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               write_enable <= 1'b0;
               done         <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_canvas_rect_writer.sv
// Scoreboard bench for canvas_rect_writer: stimulus pushes cycle-stamped
// expected writes/done events, a negedge monitor pops and compares them.
module tb_canvas_rect_writer;

   localparam int W  = 100;
   localparam int H  = 100;
   localparam int CB = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [9:0]    cmd_x0 = '0;
   logic [9:0]    cmd_y0 = '0;
   logic [9:0]    cmd_x1 = '0;
   logic [9:0]    cmd_y1 = '0;
   logic [CB-1:0] cmd_color = '0;
   logic [9:0]    writeX;
   logic [9:0]    writeY;
   logic          write_enable;
   logic [CB-1:0] write_color;
   logic          busy;
   logic          done;

   canvas_rect_writer #(
      .color_palette_bit (CB),
      .width             (W),
      .height            (H)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_x0       (cmd_x0),
      .cmd_y0       (cmd_y0),
      .cmd_x1       (cmd_x1),
      .cmd_y1       (cmd_y1),
      .cmd_color    (cmd_color),
      .writeX       (writeX),
      .writeY       (writeY),
      .write_enable (write_enable),
      .write_color  (write_color),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_done;
      int x;
      int y;
      int color;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  pass_cnt  = 0;
   int  total_cnt = 0;

   task automatic chk(input bit ok, input string name, input string act, input string req);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %s, expected %s", name, act, req);
   endtask

   // Reference: expected pixels from the clip/raster rules in plain integers.
   task automatic push_model(input int x0, input int y0, input int x1, input int y1,
                             input int color, input int hs);
      int xlo, xhi, ylo, yhi, n;
      ev_t e;
      xlo = (x0 < x1) ? x0 : x1;
      ylo = (y0 < y1) ? y0 : y1;
      xhi = (x0 < x1) ? x1 : x0;
      yhi = (y0 < y1) ? y1 : y0;
      if (xhi > W - 1) xhi = W - 1;
      if (yhi > H - 1) yhi = H - 1;
      n = 0;
      if (xlo < W && ylo < H) begin
         for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
               e = '{is_done: 1'b0, x: x, y: y, color: color, cyc: hs + n};
               exp_q.push_back(e);
               n++;
            end
         end
      end
      e = '{is_done: 1'b1, x: 0, y: 0, color: 0, cyc: hs + n};
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      bit  inflight;
      bit  ok;
      if (!rst_n) begin
         chk(!(write_enable || done), "reset_quiet",
             $sformatf("we=%0b done=%0b", write_enable, done), "we=0 done=0");
      end else begin
         inflight = (exp_q.size() > 0);
         chk(busy == inflight && cmd_ready == !inflight, "ready_busy",
             $sformatf("busy=%0b ready=%0b @%0d", busy, cmd_ready, cyc),
             $sformatf("busy=%0b ready=%0b", inflight, !inflight));
         if (write_enable || done) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_output",
                   $sformatf("we=%0b done=%0b (%0d,%0d) @%0d", write_enable, done,
                             writeX, writeY, cyc), "idle");
            end else begin
               e = exp_q.pop_front();
               if (e.is_done)
                  ok = done && !write_enable && cyc == e.cyc;
               else
                  ok = write_enable && !done && int'(writeX) == e.x && int'(writeY) == e.y &&
                       int'(write_color) == e.color && cyc == e.cyc;
               chk(ok, e.is_done ? "done_pulse" : "pixel_write",
                   $sformatf("we=%0b done=%0b (%0d,%0d) c=%0d @%0d", write_enable, done,
                             writeX, writeY, write_color, cyc),
                   e.is_done ? $sformatf("done @%0d", e.cyc)
                             : $sformatf("write (%0d,%0d) c=%0d @%0d", e.x, e.y, e.color, e.cyc));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk(1'b0, "missing_output", $sformatf("nothing @%0d", cyc),
                e.is_done ? $sformatf("done @%0d", e.cyc)
                          : $sformatf("write (%0d,%0d) @%0d", e.x, e.y, e.cyc));
         end
      end
   end

   task automatic do_cmd(input int x0, input int y0, input int x1, input int y1,
                         input int color, input bit hold);
      int n;
      int hs;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(cmd_ready, "ready_wait", $sformatf("ready=%0b", cmd_ready), "ready=1");
      cmd_x0    = 10'(x0);
      cmd_y0    = 10'(y0);
      cmd_x1    = 10'(x1);
      cmd_y1    = 10'(y1);
      cmd_color = CB'(color);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      hs = cyc;
      push_model(x0, y0, x1, y1, color, hs);
      if (!hold) begin
         // Scramble inputs to show they cannot disturb the in-flight command.
         cmd_valid = 1'b0;
         cmd_x0    = 10'($urandom_range(0, 1023));
         cmd_y0    = 10'($urandom_range(0, 1023));
         cmd_x1    = 10'($urandom_range(0, 1023));
         cmd_y1    = 10'($urandom_range(0, 1023));
         cmd_color = CB'($urandom_range(0, 3));
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((exp_q.size() > 0 || !cmd_ready) && n < 20000);
      cmd_valid = 1'b0;
      chk(n < 20000, "idle_timeout", $sformatf("%0d cycles", n), "< 20000 cycles");
      if (n >= 20000) exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(write_enable == 1'b0 && done == 1'b0 && busy == 1'b0 && cmd_ready == 1'b1,
          {tag, "_flags"},
          $sformatf("we=%0b done=%0b busy=%0b ready=%0b", write_enable, done, busy, cmd_ready),
          "we=0 done=0 busy=0 ready=1");
      chk(writeX == 10'd0 && writeY == 10'd0 && write_color == '0, {tag, "_addr"},
          $sformatf("(%0d,%0d) c=%0d", writeX, writeY, write_color), "(0,0) c=0");
   endtask

   int rx0, ry0, rx1, ry1;

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;

      do_cmd(2, 3, 4, 4, 1, 1'b0);
      wait_idle();
      do_cmd(4, 4, 2, 3, 1, 1'b0);
      wait_idle();
      do_cmd(98, 99, 200, 300, 2, 1'b0);
      wait_idle();
      do_cmd(150, 10, 160, 20, 3, 1'b0);
      wait_idle();
      do_cmd(7, 9, 7, 9, 2, 1'b0);
      wait_idle();
      do_cmd(0, 0, 99, 99, 0, 1'b1);
      wait_idle();

      // Reset after the third of six writes has been observed.
      do_cmd(10, 20, 12, 21, 2, 1'b0);
      repeat (2) @(posedge clk);
      #7;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("mid_fill_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      do_cmd(10, 20, 12, 21, 3, 1'b0);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            rx0 = $urandom_range(0, 1023);
            ry0 = $urandom_range(0, 1023);
         end else begin
            rx0 = $urandom_range(0, 110);
            ry0 = $urandom_range(0, 110);
         end
         rx1 = rx0 + $urandom_range(0, 16) - 8;
         ry1 = ry0 + $urandom_range(0, 16) - 8;
         if (rx1 < 0) rx1 = 0;
         if (ry1 < 0) ry1 = 0;
         if (rx1 > 1023) rx1 = 1023;
         if (ry1 > 1023) ry1 = 1023;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_cmd(rx0, ry0, rx1, ry1, $urandom_range(0, 3), 1'b0);
         wait_idle();
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
